sp_ram_fifo_ctrl: RTL and testbench



---
 rtl/sp_ram_fifo_ctrl.sv | 133 +++++++++++++
 tb/tb_sp_ram_fifo_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_fifo_ctrl.sv
// sp_ram_fifo_ctrl
//
// Circular-buffer FIFO controller placed directly upstream of the single-port RAM.
// The one RAM port is time-shared: each cycle carries either a read or a write.
// Reads take priority over writes.
//
// The RAM returns read data one cycle after the read address. That word is captured
// into a registered output stage. Total capacity is DEPTH + 1 words: DEPTH in the RAM
// plus one in the output register.
//
// Optional feature: define SP_FIFO_LEVEL_EN to add the level and almost_full ports.
//
// Ports:
//   clk, rst               rising-edge clock; synchronous active-high reset
//   in_valid/in_data       upstream word, accepted when in_ready is high
//   in_ready               upstream handshake; depends combinationally on out_ready
//   out_valid/out_data     registered head-of-FIFO word
//   out_ready              downstream consumes out_data this cycle
//   ram_addr/ram_data_in   RAM address and write data (ram_data_in equals in_data)
//   ram_we                 RAM write enable
//   ram_data_out           RAM read data, valid the cycle after a read address
//   level                  (SP_FIFO_LEVEL_EN) total words held
//   almost_full            (SP_FIFO_LEVEL_EN) level >= AFULL_LVL
module sp_ram_fifo_ctrl #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned AFULL_LVL = 2**ADDR_W - 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_data_out
`ifdef SP_FIFO_LEVEL_EN
    ,
    output logic [ADDR_W:0]   level,
    output logic              almost_full
`endif
);

    localparam logic [ADDR_W:0] Depth = {1'b1, {ADDR_W{1'b0}}};

    // Read-pending state: StPend marks the cycle in which RAM data is in flight.
    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StPend = 1'b1;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
    logic [0:0]        rd_pend_q, rd_pend_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic full;
    logic rd_go;
    logic wr_go;

    always_comb begin
        full = (ram_cnt_q == Depth);
        // Issue a read only when the output register will be free by capture time.
        rd_go = !rst && (rd_pend_q == StIdle) && (ram_cnt_q != '0) &&
                (!out_valid_q || out_ready);
        in_ready    = !rst && !full && !rd_go;
        wr_go       = in_valid && in_ready;
        ram_addr    = rd_go ? rd_ptr_q : wr_ptr_q;
        ram_we      = wr_go;
        ram_data_in = in_data;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_cnt_d   = ram_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        rd_pend_d   = rd_go ? StPend : StIdle;

        // rd_go and wr_go are mutually exclusive, so ram_cnt never sees both updates.
        if (wr_go) begin
            wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
            ram_cnt_d = ram_cnt_q + (ADDR_W+1)'(1);
        end else if (rd_go) begin
            rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
            ram_cnt_d = ram_cnt_q - (ADDR_W+1)'(1);
        end

        // The capture wins over a same-cycle drain: the old word leaves as the new one lands.
        if (rd_pend_q == StPend) begin
            out_valid_d = 1'b1;
            out_data_d  = ram_data_out;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_cnt_q   <= '0;
            rd_pend_q   <= StIdle;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            rd_pend_q   <= rd_pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef SP_FIFO_LEVEL_EN
    localparam logic [ADDR_W:0] AfullLvl = (ADDR_W+1)'(AFULL_LVL);

    always_comb begin
        level       = ram_cnt_q + (ADDR_W+1)'(rd_pend_q) + (ADDR_W+1)'(out_valid_q);
        almost_full = (level >= AfullLvl);
    end
`endif

endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
module tb_sp_ram_fifo_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;
    localparam int AFULL  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_ready = 1'b0;
    wire               in_ready;
    wire               out_valid;
    wire  [DATA_W-1:0] out_data;
    wire  [ADDR_W-1:0] ram_addr;
    wire  [DATA_W-1:0] ram_data_in;
    wire               ram_we;
    logic [DATA_W-1:0] ram_data_out;
`ifdef SP_FIFO_LEVEL_EN
    wire  [ADDR_W:0]   level;
    wire               almost_full;
`endif

    sp_ram_fifo_ctrl #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .AFULL_LVL(AFULL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .ram_addr    (ram_addr),
        .ram_data_in (ram_data_in),
        .ram_we      (ram_we),
        .ram_data_out(ram_data_out)
`ifdef SP_FIFO_LEVEL_EN
        ,
        .level       (level),
        .almost_full (almost_full)
`endif
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered read data.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data_in;
        ram_data_out <= mem[ram_addr];
    end

    // Reference model: words in RAM as a queue, one in-flight slot, one output slot.
    logic [7:0] ram_q[$];
    logic [7:0] in_log[$];
    logic [7:0] out_log[$];
    bit         m_pend;
    logic [7:0] m_pword;
    bit         m_ov;
    logic [7:0] m_od;
    int         m_rd;
    int         m_wr;
    int         n_checks = 0;
    int         n_fail = 0;
    int         full_block = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ram_q.delete();
        m_pend = 0;
        m_pword = '0;
        m_ov = 0;
        m_od = '0;
        m_rd = 0;
        m_wr = 0;
    endtask

    // One clock cycle: inputs already driven after the falling edge.
    task automatic cycle();
        bit rg, ir, wg, ordy;
        logic [7:0] din;
        #1;
        rg = !rst && !m_pend && ram_q.size() != 0 && (!m_ov || out_ready);
        ir = !rst && ram_q.size() < DEPTH && !rg;
        wg = in_valid && ir;
        ordy = out_ready;
        din = in_data;
        check("in_ready", in_ready, ir);
        check("out_valid", out_valid, m_ov);
        check("out_data", out_data, m_od);
        check("ram_we", ram_we, wg);
        if (rg) check("ram_addr_rd", ram_addr, m_rd % DEPTH);
        if (wg) begin
            check("ram_addr_wr", ram_addr, m_wr % DEPTH);
            check("ram_data_in", ram_data_in, din);
        end
`ifdef SP_FIFO_LEVEL_EN
        check("level", level, ram_q.size() + m_pend + m_ov);
        check("almost_full", almost_full, (ram_q.size() + m_pend + m_ov) >= AFULL);
`endif
        if (!rst && ram_q.size() == DEPTH) full_block++;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (m_ov && ordy) out_log.push_back(m_od);
            if (m_pend) begin
                m_ov = 1;
                m_od = m_pword;
            end else if (m_ov && ordy) begin
                m_ov = 0;
            end
            m_pend = rg;
            if (rg) begin
                m_pword = ram_q.pop_front();
                m_rd++;
            end
            if (wg) begin
                ram_q.push_back(din);
                in_log.push_back(din);
                m_wr++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        cycle();
        rst = 1'b0;
        in_log.delete();
        out_log.delete();
    endtask

    initial begin
        int acc;
        int base;
        // Power-up reset: DUT registers are unknown before the first edge.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_ram_we", ram_we, 0);
        @(negedge clk);
        do_reset();

        // Latency: one word, out_valid in cycle 3.
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c == 0);
            in_data  = 8'h11;
            #1;
            check("lat_we", ram_we, c == 0);
            check("lat_out_valid", out_valid, c == 3);
            if (c == 3) check("lat_out_data", out_data, 8'h11);
            cycle();
        end

        // Fill with output stalled: 5 words fit.
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        base = m_wr;
        for (int c = 0; c < 12; c++) begin
            acc = m_wr - base;
            in_data = 8'hA0 + 8'(acc);
            cycle();
        end
        #1;
        check("fill_count", m_wr - base, 5);
        check("fill_in_ready", in_ready, 0);
        check("fill_out_valid", out_valid, 1);
        check("fill_out_data", out_data, 8'hA0);
        @(negedge clk);

        // Drain in order.
        in_valid  = 1'b0;
        out_ready = 1'b1;
        out_log.delete();
        for (int c = 0; c < 14; c++) cycle();
        check("drain_count", out_log.size(), 5);
        for (int i = 0; i < 5 && i < out_log.size(); i++) begin
            check("drain_word", out_log[i], 8'hA0 + i);
        end
        #1;
        check("drain_out_valid", out_valid, 0);
        check("drain_wr_ptr_wrap", ram_addr, 1);
        @(negedge clk);

        // Streaming 0..15 with both sides open.
        out_log.delete();
        full_block = 0;
        base = m_wr;
        for (int c = 0; c < 100 && out_log.size() < 16; c++) begin
            acc = m_wr - base;
            in_valid = (acc < 16);
            in_data  = 8'(acc);
            cycle();
        end
        check("stream_count", out_log.size(), 16);
        check("stream_never_full", full_block, 0);
        for (int i = 0; i < 16 && i < out_log.size(); i++) begin
            check("stream_word", out_log[i], i);
        end

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            out_ready = (c % 100 < 40) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) cycle();
        check("rand_count", out_log.size(), in_log.size());
        for (int i = 0; i < in_log.size() && i < out_log.size(); i++) begin
            check("rand_word", out_log[i], in_log[i]);
        end

        // Reset while a read is pending: the in-flight word is dropped.
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h5C;
        cycle();
        in_valid = 1'b0;
        cycle();
        check("pend_before_rst", m_pend, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("rst_pend_out_valid", out_valid, 0);
            check("rst_pend_no_read", ram_addr, 0);
            check("rst_pend_in_ready", in_ready, 1);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
